led_code_arbiter: RTL and testbench

Shares the single status LED between up to NREQ requesters, each of which asks for a blink code: a burst of N flashes followed by a dark gap. A fixed-priority arbiter grants one request at a time. An FSM then plays the latched code using an internal tick prescaler, and returns a one-cycle acknowledge to the winner. The block sits between the PLL output clock (`clk_in`) and the `led1` pad, replacing the free-running prescaler blink; `enable` is driven from `pll_locked`.

---
 rtl/led_code_arbiter_pkg.sv | 31 +++
 rtl/led_code_arbiter_if.sv | 23 ++
 rtl/led_code_arbiter_tick_gen.sv | 30 +++
 rtl/led_code_arbiter.sv | 148 ++++++++++++++
 tb/tb_led_code_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/led_code_arbiter_pkg.sv
// led_pkg: shared types and constants for the LED blink-code arbiter.
//   - led_state_e : playback FSM states (IDLE / ON / OFF / GAP)
//   - DEF_*       : default tick timing (125 ms ticks from a 16 MHz clock)
//   - cnt_w()     : bits needed to hold a counter running 0..n-1
//   - max3()      : largest of three phase lengths, sizes the phase counter
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } led_state_e;

  localparam int DEF_TICK_DIV  = 2000000;
  localparam int DEF_ON_TICKS  = 2;
  localparam int DEF_OFF_TICKS = 2;
  localparam int DEF_GAP_TICKS = 8;

  // Never returns 0 so a degenerate counter still has a legal vector width.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/led_code_arbiter_if.sv
// led_code_if: request/acknowledge bundle between requesters and the LED
// blink-code arbiter.
//   enable : level, low forces the player idle
//   req    : NREQ level requests, bit i pairs with code slice i
//   code   : flash count of requester i in bits [i*CODE_W +: CODE_W]
//   ack    : one-hot, one-cycle completion pulse
//   busy   : high while a code is playing
//   led    : registered LED drive, active high
// master = requester side, slave = arbiter side.
interface led_code_if #(
  parameter int NREQ   = 4,
  parameter int CODE_W = 4
);
  logic                     enable;
  logic [NREQ-1:0]          req;
  logic [NREQ*CODE_W-1:0]   code;
  logic [NREQ-1:0]          ack;
  logic                     busy;
  logic                     led;

  modport master (output enable, req, code, input ack, busy, led);
  modport slave  (input enable, req, code, output ack, busy, led);
endinterface

// File: rtl/led_code_arbiter_tick_gen.sv
// led_tick_gen: prescaler producing a one-cycle tick every TICK_DIV cycles.
//   clk_in : clock, rising edge
//   rst    : asynchronous active-high reset
//   clr    : synchronous clear, counter restarts at 0 on the next cycle
//   tick   : high in the last cycle (count TICK_DIV-1) of each period
module led_tick_gen
  import led_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk_in,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = cnt_w(TICK_DIV);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == W'(TICK_DIV - 1));
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/led_code_arbiter.sv
// led_code_arbiter: shares one status LED between NREQ requesters.
// A fixed-priority arbiter (index 0 highest) grants one blink-code request,
// the FSM plays N flashes followed by a dark gap, then pulses ack for the
// winner. All outputs are registered.
//   clk_in : clock, rising edge
//   rst    : asynchronous active-high reset
//   bus    : led_code_if slave (enable, req, code in; ack, busy, led out)
module led_code_arbiter
  import led_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int CODE_W    = 4,
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int ON_TICKS  = DEF_ON_TICKS,
  parameter int OFF_TICKS = DEF_OFF_TICKS,
  parameter int GAP_TICKS = DEF_GAP_TICKS
) (
  input  logic       clk_in,
  input  logic       rst,
  led_code_if.slave  bus
);
  localparam int IDX_W = cnt_w(NREQ);
  localparam int PH_W  = cnt_w(max3(ON_TICKS, OFF_TICKS, GAP_TICKS));

  led_state_e        state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;        // ticks left in current phase, minus one
  logic [CODE_W-1:0] flash_q, flash_d;  // flashes still to start, incl. current
  logic [IDX_W-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;

  logic              tick;
  logic              tick_clr;
  logic [IDX_W-1:0]  sel_idx;
  logic [CODE_W-1:0] sel_code;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_in (clk_in),
    .rst    (rst),
    .clr    (tick_clr),
    .tick   (tick)
  );

  // Lowest set request wins; scanning downward leaves the smallest index.
  always_comb begin
    sel_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) sel_idx = IDX_W'(i);
    end
    sel_code = bus.code[sel_idx*CODE_W +: CODE_W];
  end

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    flash_d  = flash_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    tick_clr = 1'b0;

    if (!bus.enable) begin
      // Abort without ack; the latched grant is simply forgotten.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|bus.req) begin
            gnt_d = sel_idx;
            if (sel_code != '0) begin
              state_d  = ST_ON;
              flash_d  = sel_code;
              ph_d     = PH_W'(ON_TICKS - 1);
              tick_clr = 1'b1;  // phases start aligned to a tick boundary
            end else begin
              ack_d = NREQ'(1) << sel_idx;
            end
          end
        end
        ST_ON: begin
          if (tick) begin
            if (ph_q == '0) begin
              flash_d = flash_q - 1'b1;
              if (flash_q > CODE_W'(1)) begin
                state_d = ST_OFF;
                ph_d    = PH_W'(OFF_TICKS - 1);
              end else begin
                state_d = ST_GAP;
                ph_d    = PH_W'(GAP_TICKS - 1);
              end
            end else begin
              ph_d = ph_q - 1'b1;
            end
          end
        end
        ST_OFF: begin
          if (tick) begin
            if (ph_q == '0) begin
              state_d = ST_ON;
              ph_d    = PH_W'(ON_TICKS - 1);
            end else begin
              ph_d = ph_q - 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (ph_q == '0) begin
              state_d = ST_IDLE;
              ack_d   = NREQ'(1) << gnt_q;
            end else begin
              ph_d = ph_q - 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs follow the next state so they are registered yet not delayed.
    led_d  = (state_d == ST_ON);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      flash_q <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      flash_q <= flash_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.ack  = ack_q;
  assign bus.led  = led_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_led_code_arbiter.sv
// tb_led_code_arbiter: directed scoreboard bench for led_code_arbiter.
// Stimulus pushes each expected ack (value, cycle) into a queue; a forked
// monitor pops and compares whenever ack is presented. LED/busy waveforms
// are compared per cycle against hand-computed phase boundaries.
// Cycle notation: "j" counts negedge samples after the grant edge, j=1 being
// the first cycle after the grant.
module tb_led_code_arbiter;
  logic clk_in = 1'b0;
  logic rst;
  always #5 clk_in = ~clk_in;

  led_code_if #(.NREQ(4), .CODE_W(4)) bus ();

  led_code_arbiter #(
    .NREQ(4), .CODE_W(4), .TICK_DIV(4),
    .ON_TICKS(2), .OFF_TICKS(1), .GAP_TICKS(3)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] ack;
    int         at;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  function void check(input string name, input int act, input int want);
    n_checks++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, want, cyc);
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (bus.ack != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", int'(bus.ack), 0);
        end else begin
          e = exp_q.pop_front();
          check("ack_value", int'(bus.ack), int'(e.ack));
          check("ack_cycle", cyc, e.at);
          $display("txn: ack=%b at cycle %0d (expected %b at %0d)", bus.ack, cyc, e.ack, e.at);
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].at) begin
        e = exp_q.pop_front();
        check("ack_missing", 0, int'(e.ack));
      end
    end
  endtask

  // Drive a request on a negedge; the following posedge is the grant edge.
  task automatic start(input logic [3:0] r, input logic [15:0] c, output int t0);
    @(negedge clk_in);
    bus.req  = r;
    bus.code = c;
    t0 = cyc + 1;
  endtask

  task automatic goto(input int t0, input int j);
    while (cyc < t0 + j - 1) @(negedge clk_in);
  endtask

  // LED pattern of a 3-flash code: ON 8, OFF 4, ON 8, OFF 4, ON 8, GAP 12.
  function automatic int led3(input int j);
    return int'((j >= 1 && j <= 8) || (j >= 13 && j <= 20) || (j >= 25 && j <= 32));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    rst        = 1'b1;
    bus.enable = 1'b0;
    bus.req    = '0;
    bus.code   = '0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(negedge clk_in);
    check("rst_led",  int'(bus.led),  0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_ack",  int'(bus.ack),  0);
    rst        = 1'b0;
    bus.enable = 1'b1;
    repeat (2) @(negedge clk_in);

    // Single code 3 on requester 2
    $display("txn: single code 3 on req[2]");
    start(4'b0100, 16'h0300, t0);
    exp_q.push_back('{ack: 4'b0100, at: t0 + 44});
    for (int j = 1; j <= 46; j++) begin
      goto(t0, j);
      check("single_led",  int'(bus.led), led3(j));
      check("single_busy", int'(bus.busy), int'(j <= 44));
      if (j == 1) bus.req = '0;
    end

    // Priority: req[1] code 2 wins, then req[3] code 1
    $display("txn: priority req=1010 codes 2/1");
    start(4'b1010, 16'h1020, t0);
    exp_q.push_back('{ack: 4'b0010, at: t0 + 32});
    exp_q.push_back('{ack: 4'b1000, at: t0 + 53});
    for (int j = 1; j <= 56; j++) begin
      goto(t0, j);
      check("prio_led", int'(bus.led),
            int'((j <= 8) || (j >= 13 && j <= 20) || (j >= 34 && j <= 41)));
      check("prio_busy", int'(bus.busy), int'((j <= 32) || (j >= 34 && j <= 53)));
      if (j == 1)  bus.req = 4'b1000;
      if (j == 34) bus.req = 4'b0000;
    end

    // Code 0: immediate ack, nothing played
    $display("txn: code 0 on req[0]");
    start(4'b0001, 16'h0000, t0);
    exp_q.push_back('{ack: 4'b0001, at: t0});
    for (int j = 1; j <= 4; j++) begin
      goto(t0, j);
      check("zero_led",  int'(bus.led),  0);
      check("zero_busy", int'(bus.busy), 0);
      if (j == 1) bus.req = '0;
    end

    // Mid-play changes of req/code are ignored
    $display("txn: mid-play code change on req[2]");
    start(4'b0100, 16'h0300, t0);
    exp_q.push_back('{ack: 4'b0100, at: t0 + 44});
    for (int j = 1; j <= 46; j++) begin
      goto(t0, j);
      check("midplay_led",  int'(bus.led), led3(j));
      check("midplay_busy", int'(bus.busy), int'(j <= 44));
      if (j == 10) begin
        bus.req  = '0;
        bus.code = 16'hFFFF;
      end
    end

    // Abort by enable falling at T+10, request held
    $display("txn: abort via enable");
    start(4'b0100, 16'h0300, t0);
    for (int j = 1; j <= 40; j++) begin
      goto(t0, j);
      if (j <= 10) begin
        check("abort_led_pre",  int'(bus.led), led3(j));
        check("abort_busy_pre", int'(bus.busy), 1);
      end else begin
        check("abort_led",  int'(bus.led),  0);
        check("abort_busy", int'(bus.busy), 0);
      end
      if (j == 10) bus.enable = 1'b0;
    end
    @(negedge clk_in);
    bus.req    = '0;
    bus.enable = 1'b1;
    repeat (2) @(negedge clk_in);

    // Asynchronous reset mid-ON, then re-grant of the held request
    $display("txn: async reset mid-play");
    start(4'b0100, 16'h0300, t0);
    goto(t0, 15);
    check("arst_led_pre",  int'(bus.led),  1);
    check("arst_busy_pre", int'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_led",  int'(bus.led),  0);
    check("arst_busy", int'(bus.busy), 0);
    check("arst_ack",  int'(bus.ack),  0);
    @(negedge clk_in);
    check("arst_hold_busy", int'(bus.busy), 0);
    @(negedge clk_in);
    rst = 1'b0;
    t0 = cyc + 1;
    exp_q.push_back('{ack: 4'b0100, at: t0 + 44});
    for (int j = 1; j <= 46; j++) begin
      goto(t0, j);
      check("regrant_led",  int'(bus.led), led3(j));
      check("regrant_busy", int'(bus.busy), int'(j <= 44));
      if (j == 1) bus.req = '0;
    end

    repeat (2) @(negedge clk_in);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
